load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage of the RV32I core, directly downstream of execute. It accepts one load or store per transaction, with the effective address already computed as rs1+imm. It performs byte/half/word lane steering and sign/zero extension, and runs a valid/ready handshake against the data-memory port. Load results go to register writeback, and misaligned, illegal and timed-out accesses are reported as faults.

## Interface
- TIMEOUT, 16: max BUS-state cycles waiting for mem_ready before a bus fault; 0 disables the timeout.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  execute presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte effective address.
- req_wdata  in  32  store data (rs2).
- req_rd  in  5  load destination register.
- mem_valid  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  30  word address, req_addr[31:2].
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte write enables; 0000 on loads.
- mem_rdata  in  32  read word, valid when mem_ready=1.
- mem_ready  in  1  bus completes the access this cycle.
- done  out  1  one-cycle pulse when any accepted request retires, including faults.
- wb_valid  out  1  one-cycle pulse: load retired without fault and rd≠0.
- wb_rd  out  5  writeback register.
- wb_data  out  32  extended load result.
- fault  out  1  pulse coincident with done on error.
- fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout; 00 otherwise.
- fault_addr  out  32  req_addr of the faulting request.

## Operation
- FSM states are IDLE, BUS and DONE. All outputs are registered.
- IDLE
  - req_ready=1.
  - On req_valid, latch store, funct3, addr, wdata and rd, then classify:
    - Illegal funct3 goes to DONE with cause 10. Illegal for loads: 011, 110, 111. Illegal for stores: 011, 1xx.
    - Misaligned goes to DONE with cause 01. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠00.
    - Otherwise go to BUS with mem_valid=1 and the timeout counter cleared.
  - Illegal funct3 takes priority over misaligned.
- BUS
  - mem_valid, mem_we, mem_addr, mem_wdata and mem_wstrb are held stable until mem_ready.
  - On mem_ready, capture and extend rdata, then go to DONE.
  - Otherwise the counter increments. When the count reaches TIMEOUT, go to DONE with cause 11 and mem_valid=0.
- DONE
  - done=1 for exactly one cycle, together with wb_valid and/or fault as applicable.
  - Next state is IDLE unconditionally.
- Store steering:
  - SB: wdata={4{wdata[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{wdata[15:0]}}, wstrb=0011 if addr[1]=0, else 1100.
  - SW: wdata unchanged, wstrb=1111.
- Load extraction:
  - Byte lane is selected by addr[1:0]; halfword lane by addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- Faulting requests never assert mem_valid and never assert wb_valid.
- Asynchronous reset in any state:
  - State goes to IDLE.
  - mem_valid, done, wb_valid and fault go to 0 immediately.
  - Any in-flight access is discarded with no done.

## Timing
- Reset values: req_ready=1 and all other outputs 0 (fault_cause=00, wb_data=0, mem_addr=0).
- Request accepted at edge k:
  - mem_valid goes high after edge k.
  - If mem_ready=1 at edge k+1, done/wb_valid are high for cycle k+1→k+2.
  - req_ready is high again after edge k+2.
- Minimum occupancy is 3 cycles per access; each wait cycle adds 1.
- Fault path (misaligned or illegal): done/fault are high in the cycle after acceptance, and req_ready returns one cycle later.
- Timeout: mem_valid stays high for exactly TIMEOUT cycles, then done/fault follow in the next cycle.
- mem_ready is ignored when mem_valid=0.
- req_valid is ignored outside IDLE. No back-to-back acceptance.

## Test plan
- SW, addr 0x100, wdata 0xDEADBEEF, mem_ready=1 on the first mem_valid cycle -> mem_addr 0x40, wstrb 1111, mem_we=1, one done pulse, wb_valid=0, req_ready low for exactly 2 cycles.
- LB at 0x103 with rdata 0x80FF1234 -> wb_data 0xFFFFFF80; LBU at the same address -> 0x00000080; wb_rd equals req_rd.
- LH at 0x102 with rdata 0x80010000 -> wb_data 0xFFFF8001, LHU -> 0x00008001. SH at 0x102 with wdata 0x1234ABCD -> mem_wdata 0xABCDABCD, wstrb 1100.
- LW at 0x101 -> no mem_valid, fault=1 with cause 01 and fault_addr 0x101, done in the cycle after acceptance. A load with funct3 011 -> cause 10.
- TIMEOUT=16, mem_ready held 0 -> mem_valid high for 16 cycles, then done, fault, cause 11, and wb_valid=0.
- Reset asserted mid-BUS -> mem_valid drops without waiting for a clock edge, no done ever pulses, req_ready=1. A new LW at 0x8 after release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-access stage.
// Accepts one load or store at a time, steers store data onto byte lanes,
// extracts and extends load data, and talks to the data-memory port through a
// valid/ready handshake. Misaligned, illegal and timed-out accesses retire as
// faults.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | req_ready high, waiting for a request from execute
// BUS   | mem_valid high, waiting for mem_ready or the timeout count
// DONE  | one-cycle retire: done plus wb_valid and/or fault
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        done,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr
);

    // Counter only has to reach TIMEOUT-1; the terminal compare fires on the
    // last waiting cycle so mem_valid is high for exactly TIMEOUT cycles.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TC = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state;
    logic            store_q;
    logic [2:0]      funct3_q;
    logic [1:0]      lane_q;
    logic [4:0]      rd_q;
    logic [CW-1:0]   wait_cnt;

    logic            illegal;
    logic            misaligned;
    logic [31:0]     st_wdata;
    logic [3:0]      st_wstrb;

    // Sign/zero-extend the addressed byte or halfword of a read word.
    function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b100:  extend_load = {24'b0, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b101:  extend_load = {16'b0, h};
            default: extend_load = word;
        endcase
    endfunction

    // Classify the incoming request and build its store lanes.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        st_wdata   = req_wdata;
        st_wstrb   = 4'b1111;

        if (req_store)
            illegal = req_funct3[2] || (req_funct3 == 3'b011);
        else
            illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111);

        // funct3[1:0] encodes size for both loads and stores.
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = req_wdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Sequencing FSM; every output is a register written here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            rd_q        <= 5'd0;
            wait_cnt    <= '0;
            req_ready   <= 1'b1;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 30'd0;
            mem_wdata   <= 32'd0;
            mem_wstrb   <= 4'b0000;
            done        <= 1'b0;
            wb_valid    <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= 32'd0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            fault_addr  <= 32'd0;
        end else begin
            done     <= 1'b0;
            wb_valid <= 1'b0;
            fault    <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q   <= req_store;
                        funct3_q  <= req_funct3;
                        lane_q    <= req_addr[1:0];
                        rd_q      <= req_rd;
                        wait_cnt  <= '0;
                        req_ready <= 1'b0;
                        if (illegal) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_ILLEGAL;
                            fault_addr  <= req_addr;
                        end else if (misaligned) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALIGN;
                            fault_addr  <= req_addr;
                        end else begin
                            state     <= BUS;
                            mem_valid <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= req_addr[31:2];
                            mem_wdata <= st_wdata;
                            mem_wstrb <= req_store ? st_wstrb : 4'b0000;
                        end
                    end
                end

                BUS: begin
                    if (mem_ready) begin
                        state     <= DONE;
                        mem_valid <= 1'b0;
                        done      <= 1'b1;
                        if (!store_q) begin
                            wb_data  <= extend_load(funct3_q, lane_q, mem_rdata);
                            wb_rd    <= rd_q;
                            wb_valid <= (rd_q != 5'd0);
                        end
                    end else if ((TIMEOUT != 0) && (wait_cnt == TC)) begin
                        state       <= DONE;
                        mem_valid   <= 1'b0;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                        fault_addr  <= {mem_addr, lane_q};
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                DONE: begin
                    state       <= IDLE;
                    req_ready   <= 1'b1;
                    fault_cause <= CAUSE_NONE;
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single transactions
// plus hand-written timeout and mid-access reset sequences.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        done;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_addr;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .done(done), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          waits;
        logic [1:0]  cause;     // 00 = access expected to reach the bus
        logic [31:0] ex_wdata;
        logic [3:0]  ex_wstrb;
        logic        ex_wb;
        logic [31:0] ex_data;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input logic [31:0] rdata,
                                input int waits, input logic [1:0] cause,
                                input logic [31:0] ex_wdata, input logic [3:0] ex_wstrb,
                                input logic ex_wb, input logic [31:0] ex_data);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.rdata = rdata; v.waits = waits; v.cause = cause;
        v.ex_wdata = ex_wdata; v.ex_wstrb = ex_wstrb; v.ex_wb = ex_wb;
        v.ex_data = ex_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({p, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_store  = v.st;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rd     = v.rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({p, " req_ready busy"}, 32'(req_ready), 32'd0);
        if (v.cause != 2'b00) begin
            chk({p, " mem_valid"},   32'(mem_valid),   32'd0);
            chk({p, " done"},        32'(done),        32'd1);
            chk({p, " fault"},       32'(fault),       32'd1);
            chk({p, " fault_cause"}, 32'(fault_cause), 32'(v.cause));
            chk({p, " fault_addr"},  fault_addr,       v.addr);
            chk({p, " wb_valid"},    32'(wb_valid),    32'd0);
        end else begin
            chk({p, " mem_valid"}, 32'(mem_valid), 32'd1);
            chk({p, " mem_we"},    32'(mem_we),    32'(v.st));
            chk({p, " mem_addr"},  32'(mem_addr),  32'(v.addr[31:2]));
            chk({p, " mem_wstrb"}, 32'(mem_wstrb), 32'(v.ex_wstrb));
            if (v.st)
                chk({p, " mem_wdata"}, mem_wdata, v.ex_wdata);
            for (int w = 0; w < v.waits; w++) begin
                @(negedge clk);
                mem_ready = 1'b0;
                @(posedge clk); #1;
                chk({p, " held mem_valid"}, 32'(mem_valid), 32'd1);
                chk({p, " held wstrb"},     32'(mem_wstrb), 32'(v.ex_wstrb));
                chk({p, " early done"},     32'(done),      32'd0);
            end
            @(negedge clk);
            mem_ready = 1'b1;
            mem_rdata = v.rdata;
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rdata = 32'hx;
            chk({p, " done"},        32'(done),      32'd1);
            chk({p, " fault"},       32'(fault),     32'd0);
            chk({p, " mem_valid off"}, 32'(mem_valid), 32'd0);
            chk({p, " wb_valid"},    32'(wb_valid),  32'(v.ex_wb));
            chk({p, " req_ready done"}, 32'(req_ready), 32'd0);
            if (!v.st) begin
                chk({p, " wb_data"}, wb_data, v.ex_data);
                chk({p, " wb_rd"},   32'(wb_rd), 32'(v.rd));
            end
        end
        @(posedge clk); #1;
        chk({p, " done pulse end"}, 32'(done),      32'd0);
        chk({p, " req_ready back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic seen_done;

        //            st    f3      addr          wdata         rd     rdata         w  cause  ex_wdata      strb     wb    ex_data
        vecs[0]  = mk(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0,  32'h0,        0, 2'b00, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 3'b000, 32'h103, 32'h0,        5'd5,  32'h80FF1234, 0, 2'b00, 32'h0,        4'b0000, 1'b1, 32'hFFFFFF80);
        vecs[2]  = mk(1'b0, 3'b100, 32'h103, 32'h0,        5'd6,  32'h80FF1234, 1, 2'b00, 32'h0,        4'b0000, 1'b1, 32'h00000080);
        vecs[3]  = mk(1'b0, 3'b001, 32'h102, 32'h0,        5'd7,  32'h80010000, 0, 2'b00, 32'h0,        4'b0000, 1'b1, 32'hFFFF8001);
        vecs[4]  = mk(1'b0, 3'b101, 32'h102, 32'h0,        5'd8,  32'h80010000, 2, 2'b00, 32'h0,        4'b0000, 1'b1, 32'h00008001);
        vecs[5]  = mk(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0,  32'h0,        0, 2'b00, 32'hABCDABCD, 4'b1100, 1'b0, 32'h0);
        vecs[6]  = mk(1'b1, 3'b000, 32'h101, 32'h000000A5, 5'd0,  32'h0,        1, 2'b00, 32'hA5A5A5A5, 4'b0010, 1'b0, 32'h0);
        vecs[7]  = mk(1'b0, 3'b010, 32'h200, 32'h0,        5'd10, 32'hCAFEF00D, 3, 2'b00, 32'h0,        4'b0000, 1'b1, 32'hCAFEF00D);
        vecs[8]  = mk(1'b0, 3'b000, 32'h100, 32'h0,        5'd0,  32'h0000007F, 0, 2'b00, 32'h0,        4'b0000, 1'b0, 32'h0000007F);
        vecs[9]  = mk(1'b0, 3'b010, 32'h101, 32'h0,        5'd4,  32'h0,        0, 2'b01, 32'h0,        4'b0000, 1'b0, 32'h0);
        vecs[10] = mk(1'b0, 3'b011, 32'h100, 32'h0,        5'd4,  32'h0,        0, 2'b10, 32'h0,        4'b0000, 1'b0, 32'h0);
        vecs[11] = mk(1'b1, 3'b101, 32'h101, 32'h0,        5'd0,  32'h0,        0, 2'b10, 32'h0,        4'b0000, 1'b0, 32'h0);
        vecs[12] = mk(1'b1, 3'b001, 32'h103, 32'h0,        5'd0,  32'h0,        0, 2'b01, 32'h0,        4'b0000, 1'b0, 32'h0);
        vecs[13] = mk(1'b0, 3'b001, 32'h100, 32'h0,        5'd9,  32'h0000F00F, 1, 2'b00, 32'h0,        4'b0000, 1'b1, 32'hFFFFF00F);

        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        mem_rdata = 32'h0; mem_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready",   32'(req_ready),   32'd1);
        chk("rst mem_valid",   32'(mem_valid),   32'd0);
        chk("rst done",        32'(done),        32'd0);
        chk("rst fault_cause", 32'(fault_cause), 32'd0);
        chk("rst wb_data",     wb_data,          32'd0);
        chk("rst mem_addr",    32'(mem_addr),    32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++)
            run_vec(i, vecs[i]);

        // Timeout: LW with mem_ready never asserted.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h300; req_rd = 5'd12;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (mem_valid && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chk("to mem_valid cycles", 32'(n),           32'd16);
        chk("to done",             32'(done),        32'd1);
        chk("to fault",            32'(fault),       32'd1);
        chk("to cause",            32'(fault_cause), 32'd3);
        chk("to wb_valid",         32'(wb_valid),    32'd0);
        chk("to fault_addr",       fault_addr,       32'h300);
        @(posedge clk); #1;
        chk("to req_ready", 32'(req_ready), 32'd1);

        // mem_ready while idle must not retire anything.
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h55555555;
        @(posedge clk); #1;
        chk("idle ready done", 32'(done), 32'd0);
        mem_ready = 1'b0;

        // Reset in the middle of a bus access.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h40; req_rd = 5'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid mem_valid", 32'(mem_valid), 32'd1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("async mem_valid", 32'(mem_valid), 32'd0);
        chk("async req_ready", 32'(req_ready), 32'd1);
        seen_done = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen_done = seen_done | done;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen_done = seen_done | done;
        end
        chk("reset no done", 32'(seen_done), 32'd0);
        run_vec(100, mk(1'b0, 3'b010, 32'h8, 32'h0, 5'd3, 32'h11223344, 0, 2'b00,
                        32'h0, 4'b0000, 1'b1, 32'h11223344));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
